// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one adder between NUM_REQ requesters.
// One operation in flight: grant, drive a/b, wait ADD_LATENCY, capture sum, respond.
module add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_WIDTH   = 4,
  parameter int ADD_LATENCY = 0,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADD_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*ADD_WIDTH-1:0]   req_b,
  output logic [ADD_WIDTH-1:0]           add_a,
  output logic [ADD_WIDTH-1:0]           add_b,
  input  logic [ADD_WIDTH:0]             add_sum,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [ADD_WIDTH:0]             rsp_sum,
  output logic                           busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                             state;
  logic [ID_W-1:0]                    rr_ptr;
  logic [3:0]                         lat_cnt;
  logic [NUM_REQ-1:0][ADD_WIDTH-1:0]  a_arr, b_arr;
  logic [2*NUM_REQ-1:0]               rot;
  logic [ID_W:0]                      sum_idx;
  logic [ID_W-1:0]                    gnt, nxt_ptr;
  logic                               gnt_vld;

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*ADD_WIDTH +: ADD_WIDTH];
      assign b_arr[i] = req_b[i*ADD_WIDTH +: ADD_WIDTH];
    end
  endgenerate

  // Rotate so bit 0 is rr_ptr; the lowest set bit is the winner. Scanning
  // downward lets the lowest offset overwrite any higher one.
  always_comb begin
    rot     = {req_valid, req_valid} >> rr_ptr;
    gnt_vld = 1'b0;
    sum_idx = '0;
    gnt     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        sum_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      end
    end
    if (sum_idx >= (ID_W+1)'(NUM_REQ))
      sum_idx = sum_idx - (ID_W+1)'(NUM_REQ);
    gnt = sum_idx[ID_W-1:0];
  end

  assign nxt_ptr = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

  // Gated by rst so nothing is offered while the block is held in reset.
  assign req_ready = (rst && state == IDLE && gnt_vld) ? (NUM_REQ'(1) << gnt) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lat_cnt   <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          add_a   <= a_arr[gnt];
          add_b   <= b_arr[gnt];
          rsp_id  <= gnt;
          rr_ptr  <= nxt_ptr;
          lat_cnt <= 4'(ADD_LATENCY);
          busy    <= 1'b1;
          state   <= WAIT;
        end
        WAIT: if (lat_cnt != '0) begin
          lat_cnt <= lat_cnt - 1'b1;
        end else begin
          rsp_sum   <= add_sum;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: one instance with a combinational adder,
// one with ADD_LATENCY=3 and a bench-driven sum bus.
module tb_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [3:0]  req_valid0, req_ready0;
  logic [15:0] req_a0, req_b0;
  logic [3:0]  add_a0, add_b0;
  logic [4:0]  add_sum0, rsp_sum0;
  logic        rsp_valid0, rsp_ready0, busy0;
  logic [1:0]  rsp_id0;

  logic [3:0]  req_valid3, req_ready3;
  logic [15:0] req_a3, req_b3;
  logic [3:0]  add_a3, add_b3;
  logic [4:0]  add_sum3, rsp_sum3;
  logic        rsp_valid3, rsp_ready3, busy3;
  logic [1:0]  rsp_id3;

  assign add_sum0 = {1'b0, add_a0} + {1'b0, add_b0};

  add_arbiter #(.NUM_REQ(4), .ADD_WIDTH(4), .ADD_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a0), .req_b(req_b0), .add_a(add_a0), .add_b(add_b0),
    .add_sum(add_sum0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_id(rsp_id0), .rsp_sum(rsp_sum0), .busy(busy0));

  add_arbiter #(.NUM_REQ(4), .ADD_WIDTH(4), .ADD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .add_a(add_a3), .add_b(add_b3),
    .add_sum(add_sum3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .busy(busy3));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, last, w;
    int ids1 [5];
    int ids2 [4];
    ids1 = '{0, 1, 2, 3, 0};
    ids2 = '{1, 3, 1, 3};

    rst = 1'b0;
    req_valid0 = 4'hF; req_a0 = '0; req_b0 = '0; rsp_ready0 = 1'b0;
    req_valid3 = 4'h0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0; add_sum3 = '0;
    #2;
    check("rst_req_ready", req_ready0, 4'h0);
    check("rst_rsp_valid", rsp_valid0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_add_a", add_a0, 4'h0);
    check("rst_rsp_id", rsp_id0, 2'd0);
    check("rst_rsp_sum", rsp_sum0, 5'h00);
    step(); step();
    req_valid0 = 4'h0;
    rst = 1'b1;

    // single request 2: 5+3
    req_a0[8 +: 4] = 4'h5; req_b0[8 +: 4] = 4'h3; req_valid0 = 4'b0100;
    #1 check("single_ready", req_ready0, 4'b0100);
    step();
    req_valid0 = 4'h0;
    #1;
    check("single_busy", busy0, 1'b1);
    check("single_add_a", add_a0, 4'h5);
    check("single_add_b", add_b0, 4'h3);
    check("single_no_rsp_yet", rsp_valid0, 1'b0);
    check("wait_ready", req_ready0, 4'h0);
    step();
    check("single_rsp_valid", rsp_valid0, 1'b1);
    check("single_rsp_id", rsp_id0, 2'd2);
    check("single_rsp_sum", rsp_sum0, 5'h08);

    // backpressure for 5 cycles while req 0 waits
    req_a0[0 +: 4] = 4'hF; req_b0[0 +: 4] = 4'h1; req_valid0 = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", rsp_valid0, 1'b1);
      check("bp_id", rsp_id0, 2'd2);
      check("bp_sum", rsp_sum0, 5'h08);
      check("bp_ready", req_ready0, 4'h0);
    end
    rsp_ready0 = 1'b1;
    step();
    check("hs_valid_drop", rsp_valid0, 1'b0);
    check("wrap_grant", req_ready0, 4'b0001);
    check("add_a_kept", add_a0, 4'h5);

    // carry out: F+1 then F+F
    step();
    req_a0[4 +: 4] = 4'hF; req_b0[4 +: 4] = 4'hF; req_valid0 = 4'b0010;
    step();
    check("carry1_id", rsp_id0, 2'd0);
    check("carry1_sum", rsp_sum0, 5'h10);
    step();
    check("carry2_ready", req_ready0, 4'b0010);
    step();
    req_a0[12 +: 4] = 4'h7; req_b0[12 +: 4] = 4'h7; req_valid0 = 4'b1000;
    step();
    check("carry2_id", rsp_id0, 2'd1);
    check("carry2_sum", rsp_sum0, 5'h1E);
    step();
    check("rr_skip_ready", req_ready0, 4'b1000);

    // reset while in WAIT
    step();
    check("pre_rst_busy", busy0, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_add_a", add_a0, 4'h0);
    check("mid_rst_valid", rsp_valid0, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a0[i*4 +: 4] = 4'(i);
      req_b0[i*4 +: 4] = 4'h1;
    end
    req_valid0 = 4'hF;
    #1 check("post_rst_grant", req_ready0, 4'b0001);

    // rotation with all requesting, then only 1 and 3
    cyc = 0; last = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) req_valid0 = 4'b1010;
      w = 0;
      do begin
        step(); cyc++; w++;
      end while (!rsp_valid0 && w < 10);
      check("rr_seen", rsp_valid0, 1'b1);
      check("rr_id", rsp_id0, (k < 5) ? ids1[k] : ids2[k-5]);
      check("rr_sum", rsp_sum0, ((k < 5) ? ids1[k] : ids2[k-5]) + 1);
      if (k > 0) check("rr_interval", cyc - last, 3);
      last = cyc;
    end
    req_valid0 = 4'h0;

    // latency 3: only the sum present at the sampling edge is captured
    req_a3[0 +: 4] = 4'h2; req_b3[0 +: 4] = 4'h3; req_valid3 = 4'b0001; add_sum3 = 5'h1F;
    #1 check("lat_ready", req_ready3, 4'b0001);
    step();
    req_valid3 = 4'h0;
    check("lat_busy", busy3, 1'b1);
    check("lat_add_a", add_a3, 4'h2);
    for (int k = 1; k <= 3; k++) begin
      add_sum3 = 5'h10 + 5'(k);
      check("lat_no_rsp", rsp_valid3, 1'b0);
      step();
    end
    add_sum3 = 5'h05;
    check("lat_no_rsp_t4", rsp_valid3, 1'b0);
    step();
    check("lat_rsp_t5", rsp_valid3, 1'b1);
    check("lat_sum", rsp_sum3, 5'h05);
    check("lat_id", rsp_id3, 2'd0);
    add_sum3 = 5'h1A;
    step();
    check("lat_hold_sum", rsp_sum3, 5'h05);
    check("lat_hold_valid", rsp_valid3, 1'b1);
    rsp_ready3 = 1'b1;
    step();
    check("lat_done_valid", rsp_valid3, 1'b0);
    check("lat_done_busy", busy3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
